// File: rtl/amm_ddr_responder.sv
// amm_ddr_responder
//   Avalon-MM slave emulating a DDR controller user port, backed by on-chip
//   RAM. It gives deterministic init, write-stall and read-latency timing, so
//   the DRAM wrapper can be exercised in simulation or on boards without DDR.
//
// Ports
//   CLK, RST_N         clock, synchronous active-low reset
//   local_init_done    rises INIT_CYCLES cycles after reset release
//   amm_wait           waitrequest (register-driven, no input paths)
//   amm_addr           burst start word address (first beat only)
//   amm_burstcount     burst length, 0 treated as 1 (first beat only)
//   amm_wen/amm_wdata  write request / data
//   amm_ren            read request
//   amm_rvalid/rdata   read data beat
//   proto_err          sticky protocol-violation flag
module amm_ddr_responder #(
    parameter int DDR_DATA_WIDTH = 64,
    parameter int DDR_ADDR_WIDTH = 32,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int INIT_CYCLES    = 16,
    parameter int READ_LATENCY   = 4,
    parameter int WAIT_EVERY     = 8
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    output logic                      local_init_done,
    output logic                      amm_wait,
    input  logic [DDR_ADDR_WIDTH-1:0] amm_addr,
    input  logic [5:0]                amm_burstcount,
    input  logic                      amm_wen,
    input  logic [DDR_DATA_WIDTH-1:0] amm_wdata,
    input  logic                      amm_ren,
    output logic                      amm_rvalid,
    output logic [DDR_DATA_WIDTH-1:0] amm_rdata,
    output logic                      proto_err
);
    localparam int AW = MEM_DEPTH_LOG2;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_WRITE, S_READ_LAT, S_READ_DATA} state_t;

    state_t              state, state_n;
    logic [31:0]         cnt;        // init / read-latency counter
    logic [AW-1:0]       base;       // burst start word
    logic [5:0]          off;        // index of next beat within the burst
    logic [5:0]          bl;         // read burst length
    logic [5:0]          remaining;  // write beats still expected
    logic [31:0]         beat_cnt;   // accepted write beats modulo WAIT_EVERY
    logic                stall;      // one-cycle write stall

    logic [DDR_DATA_WIDTH-1:0] mem [2**AW];

    logic          beat_acc;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic          err_set;
    logic [5:0]    bl_eff;
    logic [5:0]    rem_n;
    logic [31:0]   bc_n;

    // Upper address bits are intentionally ignored (RAM aliases).
    generate
        if (DDR_ADDR_WIDTH > AW) begin : g_unused
            logic unused_addr_hi;
            assign unused_addr_hi = ^amm_addr[DDR_ADDR_WIDTH-1:AW];
        end
    endgenerate

    assign amm_wait = (state == S_INIT) || (state == S_READ_LAT) ||
                      (state == S_READ_DATA) || stall;

    always_comb begin
        state_n   = state;
        beat_acc  = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = '0;
        err_set   = 1'b0;
        bl_eff    = (amm_burstcount == 6'd0) ? 6'd1 : amm_burstcount;
        case (state)
            S_INIT: if (cnt == 32'(INIT_CYCLES - 1)) state_n = S_IDLE;
            S_IDLE: begin
                if (amm_wen) begin
                    beat_acc  = 1'b1;
                    mem_we    = 1'b1;
                    mem_waddr = amm_addr[AW-1:0];
                    if (bl_eff != 6'd1) state_n = S_WRITE;
                    if (amm_ren || amm_burstcount == 6'd0) err_set = 1'b1;
                end else if (amm_ren) begin
                    state_n = S_READ_LAT;
                    if (amm_burstcount == 6'd0) err_set = 1'b1;
                end
            end
            S_WRITE: begin
                if (amm_ren) err_set = 1'b1;
                if (amm_wen && !stall) begin
                    beat_acc  = 1'b1;
                    mem_we    = 1'b1;
                    mem_waddr = base + AW'(off);
                    if (remaining == 6'd1) state_n = S_IDLE;
                end
            end
            S_READ_LAT:  if (cnt == 32'(READ_LATENCY - 2)) state_n = S_READ_DATA;
            S_READ_DATA: if (off == bl) state_n = S_IDLE;
            default:     state_n = S_INIT;
        endcase
        // Beats left after this one, and burst-wide beat count for stalls.
        rem_n = (state == S_IDLE) ? bl_eff - 6'd1 : remaining - 6'd1;
        bc_n  = ((state == S_IDLE) ? 32'd0 : beat_cnt) + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (mem_we && RST_N) mem[mem_waddr] <= amm_wdata;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state           <= S_INIT;
            cnt             <= '0;
            base            <= '0;
            off             <= '0;
            bl              <= '0;
            remaining       <= '0;
            beat_cnt        <= '0;
            stall           <= 1'b0;
            local_init_done <= 1'b0;
            amm_rvalid      <= 1'b0;
            amm_rdata       <= '0;
            proto_err       <= 1'b0;
        end else begin
            state <= state_n;
            if (err_set) proto_err <= 1'b1;

            stall <= 1'b0;
            if (beat_acc) begin
                if (WAIT_EVERY > 0 && bc_n == 32'(WAIT_EVERY)) begin
                    beat_cnt <= '0;
                    stall    <= (rem_n != 6'd0);
                end else begin
                    beat_cnt <= bc_n;
                end
            end

            case (state)
                S_INIT: begin
                    cnt <= cnt + 32'd1;
                    if (state_n == S_IDLE) local_init_done <= 1'b1;
                end
                S_IDLE: begin
                    cnt <= '0;
                    if (amm_wen) begin
                        base      <= amm_addr[AW-1:0];
                        off       <= 6'd1;
                        remaining <= rem_n;
                    end else if (amm_ren) begin
                        base <= amm_addr[AW-1:0];
                        bl   <= bl_eff;
                    end
                end
                S_WRITE: if (beat_acc) begin
                    off       <= off + 6'd1;
                    remaining <= rem_n;
                end
                S_READ_LAT: begin
                    cnt <= cnt + 32'd1;
                    if (state_n == S_READ_DATA) begin
                        amm_rvalid <= 1'b1;
                        amm_rdata  <= mem[base];
                        off        <= 6'd1;
                    end
                end
                S_READ_DATA: begin
                    if (off == bl) begin
                        amm_rvalid <= 1'b0;   // rdata keeps the last beat
                    end else begin
                        amm_rvalid <= 1'b1;
                        amm_rdata  <= mem[base + AW'(off)];
                        off        <= off + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/amm_ddr_responder.md
Name: amm_ddr_responder

Overview:
- Avalon-MM slave that emulates the DDR controller's user port; the responder end of the amm_* master interface driven by the DRAM wrapper under the PCIe channel tester.
- Backs the address space with on-chip RAM and produces local_init_done, amm_wait, amm_rvalid and amm_rdata with deterministic timing.
- Used as the memory model in simulation and in FPGA builds without external DDR.

Parameters:
DDR_DATA_WIDTH, 64, data beat width
DDR_ADDR_WIDTH, 32, amm_addr width; word address, one word = one beat
MEM_DEPTH_LOG2, 10, RAM depth = 2^MEM_DEPTH_LOG2 words; amm_addr[MEM_DEPTH_LOG2-1:0] indexes RAM, upper bits ignored
INIT_CYCLES, 16, cycles after reset release before local_init_done rises (>=1)
READ_LATENCY, 4, cycles from accepted read command to first amm_rvalid (>=2)
WAIT_EVERY, 8, in write bursts insert one amm_wait cycle after every WAIT_EVERY accepted beats; 0 = never

Ports:
CLK  input  1  clock
RST_N  input  1  synchronous active-low reset
local_init_done  output  1  calibration-complete emulation
amm_wait  output  1  waitrequest; command/beat accepted only when amm_wait=0
amm_addr  input  DDR_ADDR_WIDTH  burst start word address (sampled on first beat only)
amm_burstcount  input  6  beats in burst (sampled on first beat only)
amm_wen  input  1  write request
amm_wdata  input  DDR_DATA_WIDTH  write data
amm_ren  input  1  read request
amm_rvalid  output  1  read data valid
amm_rdata  output  DDR_DATA_WIDTH  read data
proto_err  output  1  sticky protocol-violation flag

Behaviour:
- One clock (CLK); reset is synchronous and active-low (RST_N). RST_N=0 at a CLK edge -> state INIT, all counters 0, local_init_done=0, amm_wait=1, amm_rvalid=0, amm_rdata=0, proto_err=0. RAM contents are not cleared. Reset mid-burst aborts the burst; no further rvalid.
- States: INIT, IDLE, WRITE, READ_LAT, READ_DATA.
- INIT: amm_wait=1; counts INIT_CYCLES cycles after RST_N goes high; then local_init_done=1 (stays 1 until reset) and -> IDLE.
- IDLE: amm_wait=0. Effective burst length BL = amm_burstcount, except 0 -> 1 with proto_err set.
- IDLE, amm_wen=1: write amm_wdata to RAM[addr]; latch base=addr and remaining=BL-1; remaining>0 -> WRITE, else stay IDLE.
- IDLE, amm_ren=1, amm_wen=0: latch base and BL -> READ_LAT.
- IDLE, amm_wen and amm_ren both 1: write is served, read is dropped, proto_err set.
- WRITE: beat i (i=1..BL-1) is accepted when amm_wen=1 and amm_wait=0, and is written to RAM[(base+i) mod 2^MEM_DEPTH_LOG2].
  - amm_addr and amm_burstcount are ignored for beats after the first.
  - amm_wen=0 is a legal gap: the cycle is idle.
  - amm_ren=1 in WRITE sets proto_err and is otherwise ignored.
  - Last beat accepted -> IDLE.
- Write stall: with WAIT_EVERY>0, a beat counter (spanning the whole burst, first beat included) is kept. After each WAIT_EVERY-th accepted beat, if beats remain, amm_wait=1 for exactly the next cycle. amm_wait is driven from registers only.
- READ_LAT: amm_wait=1. A read accepted at edge T gives the first amm_rvalid=1 in the cycle after edge T+READ_LATENCY-1, i.e. READ_LATENCY cycles after acceptance.
- READ_DATA: amm_wait=1; amm_rvalid=1 for BL consecutive cycles with amm_rdata = RAM[(base+k) mod depth], k=0..BL-1, no gaps. After the last beat -> IDLE; amm_rvalid=0 and amm_wait=0 in the following cycle.
- amm_rdata holds its last value when amm_rvalid=0.
- Address arithmetic is modulo 2^MEM_DEPTH_LOG2: bursts wrap silently from the top word to word 0.
- Read-after-write: a read issued the cycle after a write burst completes returns the new data.
- One outstanding command at a time; no read pipelining.
- proto_err clears only on reset.

Test Plan:
- Reset release: RST_N 0->1 -> local_init_done=0, amm_wait=1 for 16 cycles, then local_init_done=1, amm_wait=0; amm_rvalid never 1.
- Single beat: write addr 5 data 0xDEADBEEF_00000005 (burst 1), then read addr 5 burst 1 -> rvalid exactly 4 cycles after read acceptance, rdata=0xDEADBEEF_00000005, wait low the cycle after rvalid.
- Burst 32 with stalls: write addr 0x100, 32 beats with data=index -> amm_wait=1 single cycles after beats 8, 16 and 24; read back 32 beats -> 32 contiguous rvalid cycles, data 0..31.
- Wrap: write burst 4 at addr 1022 (depth 1024) with data A,B,C,D -> read addr 0 burst 2 returns C,D; read addr 1022 burst 2 returns A,B.
- Protocol errors: amm_wen and amm_ren both 1 in IDLE -> write stored, no rvalid, proto_err=1; burstcount=0 -> treated as 1 beat, proto_err=1.
- Reset mid-read: RST_N=0 during READ_DATA beat 3 of 8 -> rvalid=0 next cycle, re-init sequence; earlier RAM contents still readable after init.
